// File: rtl/lrc_pkg.sv
// Shared types and helpers for the LRC receive checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lrc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] LRC_INIT     = 8'h00;
  localparam int         LRC_ERRCNT_W = 16;

  // Two's complement of the running sum; the LRC makes payload + check wrap to zero.
  function automatic logic [7:0] lrc_finalize(input logic [7:0] sum);
    return (sum ^ 8'hFF) + 8'h01;
  endfunction

endpackage

// File: rtl/lrc_accum.sv
// Mod-256 byte accumulator with synchronous clear and add enable; exposes sum and its LRC.
// Latency: sum updates one cycle after en; lrc is combinational from sum.
// Backpressure: none, the caller qualifies en.
module lrc_accum
  import lrc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum,
  output logic [7:0] lrc
);

  // Clear has priority over add; the sum wraps with no carry kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= LRC_INIT;
    end else if (clr) begin
      sum <= LRC_INIT;
    end else if (en) begin
      sum <= sum + din;
    end
  end

  // LRC of whatever has been accumulated so far.
  always_comb begin
    lrc = lrc_finalize(sum);
  end

endmodule

// File: rtl/lrc_check.sv
// Receive-side LRC checker: verdict, length and overrun once per frame (optional err_count via LRC_CHECK_STATS_EN).
// Latency: result pulse (res_valid) one cycle after the check byte is accepted.
// Backpressure: in_ready drops for the single REPORT cycle and while in reset; otherwise always ready.
module lrc_check
  import lrc_pkg::*;
#(
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_overrun,
  output logic [7:0]       res_lrc,
`ifdef LRC_CHECK_STATS_EN
  output logic [LRC_ERRCNT_W-1:0] err_count,
`endif
  output logic [LEN_W-1:0] res_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t           state, state_nxt;
  logic             accept;
  logic             acc_clr, acc_en, ld_res;
  logic [7:0]       acc_sum, acc_lrc;
  logic [LEN_W-1:0] len;
  logic             overrun;
  logic             chk_match;

  lrc_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (in_data),
    .sum   (acc_sum),
    .lrc   (acc_lrc)
  );

  // Ready is held low while reset is asserted and for the report bubble.
  always_comb begin
    in_ready  = rst_n && (state != REPORT);
    accept    = in_valid && in_ready;
    res_valid = (state == REPORT);
    // Check byte matches the LRC exactly when payload sum plus check wraps to zero.
    chk_match = ((acc_sum + in_data) == 8'h00);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and accumulator / result-load strobes.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    ld_res    = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            ld_res    = 1'b1;
            state_nxt = REPORT;
          end else begin
            acc_en    = 1'b1;
            state_nxt = ACCUM;
          end
        end
      end
      REPORT: begin
        acc_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        acc_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Payload length saturates at MAX_LEN; further payload bytes flag overrun but still feed the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      overrun <= 1'b0;
    end else if (state == REPORT) begin
      len     <= '0;
      overrun <= 1'b0;
    end else if (accept && !in_last) begin
      if (state == IDLE) begin
        len <= LEN_W'(1);
      end else if (len < LEN_MAX) begin
        len <= len + LEN_W'(1);
      end else begin
        overrun <= 1'b1;
      end
    end
  end

  // Result fields captured on the check beat and held until the next frame's check beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ok      <= 1'b0;
      res_overrun <= 1'b0;
      res_lrc     <= 8'h00;
      res_len     <= '0;
    end else if (ld_res) begin
      res_ok      <= chk_match && !overrun;
      res_overrun <= overrun;
      res_lrc     <= acc_lrc;
      res_len     <= len;
    end
  end

`ifdef LRC_CHECK_STATS_EN
  // Saturating count of failed frames, bumped during the report cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (res_valid && !res_ok && (err_count != {LRC_ERRCNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lrc_check.sv
// Directed bench for lrc_check with MAX_LEN=4; expected values are hand-computed LRCs.
// Latency: checks res_valid on the first negedge after the check beat's accepting edge.
// Backpressure: beats wait (bounded) on in_ready; the bubble width is measured.
module tb_lrc_check;

  localparam int MAX_LEN = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             res_valid;
  logic             res_ok;
  logic             res_overrun;
  logic [7:0]       res_lrc;
  logic [LEN_W-1:0] res_len;
`ifdef LRC_CHECK_STATS_EN
  logic [15:0]      err_count;
`endif

  int nvec = 0;
  int nmis = 0;
  int nres = 0;
  int stalls;
  int base;

  lrc_check #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .res_valid   (res_valid),
    .res_ok      (res_ok),
    .res_overrun (res_overrun),
    .res_lrc     (res_lrc),
`ifdef LRC_CHECK_STATS_EN
    .err_count   (err_count),
`endif
    .res_len     (res_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result pulses, sampled away from the active edge.
  always @(negedge clk) if (rst_n && res_valid) nres++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat from a negedge and hold it until accepted; reports ready-low cycles seen.
  task automatic beat(input logic [7:0] d, input logic last, output int stl);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    stl      = 0;
    while (!in_ready && stl < 20) begin
      stl++;
      @(negedge clk);
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic expect_result(input string tag, input logic ok, input logic [7:0] lrc,
                               input logic [LEN_W-1:0] len, input logic ovr,
                               input logic [15:0] errs);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, res_valid, 1'b1);
    check({tag, "_rdy_bubble"}, in_ready, 1'b0);
    check({tag, "_ok"}, res_ok, ok);
    check({tag, "_lrc"}, res_lrc, lrc);
    check({tag, "_len"}, res_len, len);
    check({tag, "_ovr"}, res_overrun, ovr);
    @(negedge clk);
    check({tag, "_pulse_end"}, res_valid, 1'b0);
    check({tag, "_hold_lrc"}, res_lrc, lrc);
`ifdef LRC_CHECK_STATS_EN
    check({tag, "_errcnt"}, err_count, errs);
`else
    if (errs == 16'hFFFF) $display("note: unused error count");
`endif
  endtask

  task automatic payload(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) beat(d, 1'b0, stalls);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", res_valid, 1'b0);
    check("rst_ok", res_ok, 1'b0);
    check("rst_lrc", res_lrc, 8'h00);
    check("rst_len", res_len, 0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", in_ready, 1'b1);

    // 01+02+03 = 06, LRC FA.
    beat(8'h01, 1'b0, stalls); beat(8'h02, 1'b0, stalls); beat(8'h03, 1'b0, stalls);
    beat(8'hFA, 1'b1, stalls);
    expect_result("good3", 1'b1, 8'hFA, 3, 1'b0, 16'd0);

    // Same payload, wrong check byte.
    beat(8'h01, 1'b0, stalls); beat(8'h02, 1'b0, stalls); beat(8'h03, 1'b0, stalls);
    beat(8'hFB, 1'b1, stalls);
    expect_result("bad3", 1'b0, 8'hFA, 3, 1'b0, 16'd1);

    // Empty frames: LRC of nothing is 00.
    beat(8'h00, 1'b1, stalls);
    expect_result("empty_ok", 1'b1, 8'h00, 0, 1'b0, 16'd1);
    beat(8'h5A, 1'b1, stalls);
    expect_result("empty_bad", 1'b0, 8'h00, 0, 1'b0, 16'd2);

    // Wrap: FF+02 = 01, LRC FF; next frame follows with valid held high.
    beat(8'hFF, 1'b0, stalls); beat(8'h02, 1'b0, stalls);
    beat(8'hFF, 1'b1, stalls);
    beat(8'h10, 1'b0, stalls);
    check("b2b_bubble", stalls, 1);
    check("wrap_ok", res_ok, 1'b1);
    check("wrap_lrc", res_lrc, 8'hFF);
    check("wrap_len", res_len, 2);
    beat(8'hF0, 1'b1, stalls);
    check("b2b_no_stall", stalls, 0);
    expect_result("b2b2", 1'b1, 8'hF0, 1, 1'b0, 16'd2);

    // Exactly MAX_LEN bytes: sum 04, LRC FC, no overrun.
    payload(8'h01, 4);
    beat(8'hFC, 1'b1, stalls);
    expect_result("maxlen", 1'b1, 8'hFC, 4, 1'b0, 16'd2);

    // One past MAX_LEN: sum 05, LRC FB, length saturates, verdict forced bad.
    payload(8'h01, 5);
    beat(8'hFB, 1'b1, stalls);
    expect_result("overrun", 1'b0, 8'hFB, 4, 1'b1, 16'd3);

    // Overrun state must not leak into the next frame.
    beat(8'h07, 1'b0, stalls);
    beat(8'hF9, 1'b1, stalls);
    expect_result("post_ovr", 1'b1, 8'hF9, 1, 1'b0, 16'd3);

    // Reset mid-frame discards the partial sum and clears everything.
    beat(8'h11, 1'b0, stalls); beat(8'h22, 1'b0, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_lrc", res_lrc, 8'h00);
    check("mid_rst_len", res_len, 0);
`ifdef LRC_CHECK_STATS_EN
    check("mid_rst_errcnt", err_count, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    base  = nres;
    beat(8'h07, 1'b0, stalls);
    beat(8'hF9, 1'b1, stalls);
    expect_result("after_rst", 1'b1, 8'hF9, 1, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check("after_rst_reports", nres - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
